// File: rtl/rf_pkg.sv
// Shared widths, the "no pending producer" tag value and index/tag types
// used by the rename register file and its read ports.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREG_DEF  = 32;
    localparam int TAG_W_DEF = 3;
    localparam int RW_DEF    = $clog2(NREG_DEF);

    // Tag 0 never names a real producer; it marks a register value as ready.
    localparam int NO_DEP = 0;

    typedef logic [TAG_W_DEF-1:0] tag_t;
    typedef logic [RW_DEF-1:0]    reg_idx_t;

endpackage

// File: rtl/rf_read_port.sv
// One operand lookup: passes through the stored value/tag and, when
// RF_COMMIT_BYPASS_EN is defined, forwards a same-cycle matching commit.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int RW    = RW_DEF
) (
    input  logic [RW-1:0]    rs,
    input  logic [XLEN-1:0]  reg_val,
    input  logic [TAG_W-1:0] reg_tag,
    input  logic             commit_valid,
    input  logic [RW-1:0]    commit_reg,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic [XLEN-1:0]  commit_data,
    output logic [XLEN-1:0]  val,
    output logic [TAG_W-1:0] tag
);

`ifdef RF_COMMIT_BYPASS_EN
    // The producer we would wait on is retiring right now: hand its result over.
    always_comb begin
        val = reg_val;
        tag = reg_tag;
        if (commit_valid && (commit_reg == rs) && (rs != '0) && (reg_tag == commit_tag)) begin
            val = commit_data;
            tag = TAG_W'(NO_DEP);
        end
    end
`else
    // Without bypass the consumer snoops the result bus for the pending tag.
    logic unused_bypass_inputs;
    assign unused_bypass_inputs = ^{rs, commit_valid, commit_reg, commit_tag, commit_data};

    always_comb begin
        val = reg_val;
        tag = reg_tag;
    end
`endif

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register producer tags for renaming.
// Optional same-cycle commit forwarding is enabled by RF_COMMIT_BYPASS_EN.
module rename_regfile
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREG  = NREG_DEF,
    parameter int TAG_W = TAG_W_DEF,
    localparam int RW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             commit_valid,
    input  logic [RW-1:0]    commit_reg,
    input  logic [TAG_W-1:0] commit_tag,
    input  logic [XLEN-1:0]  commit_data,
    input  logic             issue_valid,
    input  logic [RW-1:0]    issue_rs1,
    input  logic [RW-1:0]    issue_rs2,
    input  logic [RW-1:0]    issue_rd,
    input  logic [TAG_W-1:0] issue_tag,
    output logic             out_valid,
    output logic [XLEN-1:0]  out_val1,
    output logic [XLEN-1:0]  out_val2,
    output logic [TAG_W-1:0] out_tag1,
    output logic [TAG_W-1:0] out_tag2
);

    logic [XLEN-1:0]  regs [NREG];
    logic [TAG_W-1:0] tags [NREG];

    logic             accept;
    logic [XLEN-1:0]  look_val1;
    logic [XLEN-1:0]  look_val2;
    logic [TAG_W-1:0] look_tag1;
    logic [TAG_W-1:0] look_tag2;

    assign accept = issue_valid && !flush;

    rf_read_port #(.XLEN(XLEN), .TAG_W(TAG_W), .RW(RW)) u_port1 (
        .rs           (issue_rs1),
        .reg_val      (regs[issue_rs1]),
        .reg_tag      (tags[issue_rs1]),
        .commit_valid (commit_valid),
        .commit_reg   (commit_reg),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data),
        .val          (look_val1),
        .tag          (look_tag1)
    );

    rf_read_port #(.XLEN(XLEN), .TAG_W(TAG_W), .RW(RW)) u_port2 (
        .rs           (issue_rs2),
        .reg_val      (regs[issue_rs2]),
        .reg_tag      (tags[issue_rs2]),
        .commit_valid (commit_valid),
        .commit_reg   (commit_reg),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data),
        .val          (look_val2),
        .tag          (look_tag2)
    );

    // Entry 0 is only ever written by reset, so register 0 reads 0/ready forever.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (commit_valid && (commit_reg == RW'(i))) begin
                    regs[i] <= commit_data;
                end
                if (flush) begin
                    tags[i] <= TAG_W'(NO_DEP);
                end else begin
                    // Later assignment wins: a new producer overrides a retiring one.
                    if (commit_valid && (commit_reg == RW'(i)) && (tags[i] == commit_tag)) begin
                        tags[i] <= TAG_W'(NO_DEP);
                    end
                    if (accept && (issue_rd == RW'(i)) && (issue_tag != TAG_W'(NO_DEP))) begin
                        tags[i] <= issue_tag;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_val1  <= '0;
            out_val2  <= '0;
            out_tag1  <= '0;
            out_tag2  <= '0;
        end else begin
            out_valid <= accept;
            if (accept) begin
                out_val1 <= look_val1;
                out_val2 <= look_val2;
                out_tag1 <= look_tag1;
                out_tag2 <= look_tag2;
            end
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Directed table-driven bench for rename_regfile; expectations follow the
// build's RF_COMMIT_BYPASS_EN setting.
module tb_rename_regfile;
    import rf_pkg::*;

    localparam int XLEN  = 32;
    localparam int TAG_W = 3;
    localparam int RW    = 5;
    localparam int EXP_W = 1 + XLEN + TAG_W + XLEN + TAG_W;

`ifdef RF_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             flush;
    logic             commit_valid;
    reg_idx_t         commit_reg;
    tag_t             commit_tag;
    logic [XLEN-1:0]  commit_data;
    logic             issue_valid;
    reg_idx_t         issue_rs1;
    reg_idx_t         issue_rs2;
    reg_idx_t         issue_rd;
    tag_t             issue_tag;
    logic             out_valid;
    logic [XLEN-1:0]  out_val1;
    logic [XLEN-1:0]  out_val2;
    tag_t             out_tag1;
    tag_t             out_tag2;

    int tests  = 0;
    int failed = 0;
    logic [EXP_W-1:0] exp_q[$];

    rename_regfile dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .commit_valid (commit_valid),
        .commit_reg   (commit_reg),
        .commit_tag   (commit_tag),
        .commit_data  (commit_data),
        .issue_valid  (issue_valid),
        .issue_rs1    (issue_rs1),
        .issue_rs2    (issue_rs2),
        .issue_rd     (issue_rd),
        .issue_tag    (issue_tag),
        .out_valid    (out_valid),
        .out_val1     (out_val1),
        .out_val2     (out_val2),
        .out_tag1     (out_tag1),
        .out_tag2     (out_tag2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        cv;
        logic [4:0]  creg;
        logic [2:0]  ctag;
        logic [31:0] cdata;
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  itag;
        logic        ev;
        logic [31:0] ev1;
        logic [2:0]  et1;
        logic [31:0] ev2;
        logic [2:0]  et2;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    function automatic vec_t mk(logic fl, logic cv, logic [4:0] creg, logic [2:0] ctag,
                                logic [31:0] cdata, logic iv, logic [4:0] rs1, logic [4:0] rs2,
                                logic [4:0] rd, logic [2:0] itag, logic ev, logic [31:0] ev1,
                                logic [2:0] et1, logic [31:0] ev2, logic [2:0] et2);
        vec_t v;
        v.flush = fl;  v.cv = cv;   v.creg = creg; v.ctag = ctag; v.cdata = cdata;
        v.iv = iv;     v.rs1 = rs1; v.rs2 = rs2;   v.rd = rd;     v.itag = itag;
        v.ev = ev;     v.ev1 = ev1; v.et1 = et1;   v.ev2 = ev2;   v.et2 = et2;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_idle();
        flush = 1'b0; commit_valid = 1'b0; commit_reg = '0; commit_tag = '0; commit_data = '0;
        issue_valid = 1'b0; issue_rs1 = '0; issue_rs2 = '0; issue_rd = '0; issue_tag = '0;
    endtask

    task automatic drive_vec(input vec_t v);
        flush = v.flush; commit_valid = v.cv; commit_reg = v.creg; commit_tag = v.ctag;
        commit_data = v.cdata; issue_valid = v.iv; issue_rs1 = v.rs1; issue_rs2 = v.rs2;
        issue_rd = v.rd; issue_tag = v.itag;
        exp_q.push_back({v.ev, v.ev1, v.et1, v.ev2, v.et2});
    endtask

    // scoreboard: compare the oldest expectation against the registered outputs
    task automatic score(input int idx);
        logic [EXP_W-1:0] e;
        logic             ev;
        logic [31:0]      ev1;
        logic [31:0]      ev2;
        logic [2:0]       et1;
        logic [2:0]       et2;
        if (exp_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL scoreboard_empty vec %0d: got 0 entries expected 1", idx);
            return;
        end
        e = exp_q.pop_front();
        {ev, ev1, et1, ev2, et2} = e;
        check($sformatf("v%0d_valid", idx), 32'(out_valid), 32'(ev));
        if (ev) begin
            check($sformatf("v%0d_val1", idx), out_val1, ev1);
            check($sformatf("v%0d_tag1", idx), 32'(out_tag1), 32'(et1));
            check($sformatf("v%0d_val2", idx), out_val2, ev2);
            check($sformatf("v%0d_tag2", idx), 32'(out_tag2), 32'(et2));
        end
    endtask

    initial begin
        //            fl cv creg ctag cdata     iv rs1 rs2 rd ti  ev ev1    et1 ev2    et2
        vecs[0]  = mk(0, 0, 0,  0, 32'h0,     1, 5,  0,  0, 0,  1, 32'h0, 0, 32'h0, 0);
        vecs[1]  = mk(0, 0, 0,  0, 32'h0,     1, 0,  4, 14, 3,  1, 32'h0, 0, 32'h0, 0);
        vecs[2]  = mk(0, 0, 0,  0, 32'h0,     1, 14, 3,  0, 0,  1, 32'h0, 3, 32'h0, 0);
        vecs[3]  = mk(0, 1, 14, 2, 32'h7,     0, 0,  0,  0, 0,  0, 32'h0, 0, 32'h0, 0);
        vecs[4]  = mk(0, 0, 0,  0, 32'h0,     1, 14, 14, 0, 0,  1, 32'h7, 3, 32'h7, 3);
        vecs[5]  = mk(0, 1, 14, 3, 32'h55,    0, 0,  0,  0, 0,  0, 32'h0, 0, 32'h0, 0);
        vecs[6]  = mk(0, 0, 0,  0, 32'h0,     1, 14, 5, 14, 3,  1, 32'h55, 0, 32'h0, 0);
        vecs[7]  = mk(0, 0, 0,  0, 32'h0,     1, 14, 14, 0, 0,  1, 32'h55, 3, 32'h55, 3);
        vecs[8]  = mk(0, 1, 14, 3, 32'hAA,    1, 14, 0,  0, 0,  1, BYP ? 32'hAA : 32'h55,
                      BYP ? 3'd0 : 3'd3, 32'h0, 0);
        vecs[9]  = mk(0, 0, 0,  0, 32'h0,     1, 14, 14, 0, 0,  1, 32'hAA, 0, 32'hAA, 0);
        vecs[10] = mk(0, 0, 0,  0, 32'h0,     1, 0,  0,  9, 2,  1, 32'h0, 0, 32'h0, 0);
        vecs[11] = mk(0, 1, 9,  2, 32'h99,    1, 0,  0,  9, 4,  1, 32'h0, 0, 32'h0, 0);
        vecs[12] = mk(0, 0, 0,  0, 32'h0,     1, 9,  9,  0, 0,  1, 32'h99, 4, 32'h99, 4);
        vecs[13] = mk(0, 0, 0,  0, 32'h0,     1, 1,  0,  1, 1,  1, 32'h0, 0, 32'h0, 0);
        vecs[14] = mk(0, 0, 0,  0, 32'h0,     1, 1,  2,  2, 2,  1, 32'h0, 1, 32'h0, 0);
        vecs[15] = mk(0, 0, 0,  0, 32'h0,     1, 0,  0, 14, 5,  1, 32'h0, 0, 32'h0, 0);
        vecs[16] = mk(1, 1, 2,  7, 32'h22,    1, 14, 0,  7, 6,  0, 32'h0, 0, 32'h0, 0);
        vecs[17] = mk(0, 0, 0,  0, 32'h0,     1, 1,  2,  0, 0,  1, 32'h0, 0, 32'h22, 0);
        vecs[18] = mk(0, 0, 0,  0, 32'h0,     1, 14, 7,  0, 0,  1, 32'hAA, 0, 32'h0, 0);
        vecs[19] = mk(0, 0, 0,  0, 32'h0,     1, 9,  0,  0, 0,  1, 32'h99, 0, 32'h0, 0);
        vecs[20] = mk(0, 1, 0,  0, 32'h123,   1, 0,  0,  0, 3,  1, 32'h0, 0, 32'h0, 0);
        vecs[21] = mk(0, 0, 0,  0, 32'h0,     1, 0,  0,  0, 0,  1, 32'h0, 0, 32'h0, 0);
        vecs[22] = mk(0, 0, 0,  0, 32'h0,     0, 0,  0,  0, 0,  0, 32'h0, 0, 32'h0, 0);
        vecs[23] = mk(0, 0, 0,  0, 32'h0,     1, 9,  14, 0, 0,  1, 32'h99, 0, 32'hAA, 0);

        // Reset with issue/commit asserted: both must be ignored.
        rst = 1'b0;
        drive_idle();
        issue_valid = 1'b1; issue_rd = 5'd3; issue_tag = 3'd5;
        commit_valid = 1'b1; commit_reg = 5'd4; commit_data = 32'h44;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'h0);
        check("reset_val1", out_val1, 32'h0);
        check("reset_tag2", 32'(out_tag2), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive_idle();

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            @(posedge clk);
            #1;
            score(i);
        end

        // Asynchronous reset mid-cycle clears outputs without a clock edge.
        @(negedge clk);
        drive_idle();
        #2 rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'h0);
        check("async_rst_val1", out_val1, 32'h0);
        check("async_rst_val2", out_val2, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        issue_valid = 1'b1; issue_rs1 = 5'd14; issue_rs2 = 5'd9;
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(out_valid), 32'h1);
        check("post_rst_val1", out_val1, 32'h0);
        check("post_rst_val2", out_val2, 32'h0);
        check("post_rst_tag1", 32'(out_tag1), 32'h0);
        @(negedge clk);
        drive_idle();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

endmodule
